// File: rtl/spi_slave_port.sv
// SPI mode-0 responder (MSB first) with a CPU register window; all SPI pins oversampled in clk.
// Latency: RXF/irq rise SYNC_STAGES+1..+2 clk after the 8th sck rise at the pin; DO is combinational on AD.
// No backpressure: an unread byte is overwritten (OVR), an unqueued reply sends FILL_BYTE (UND).
module spi_slave_port #(
  parameter int         SYNC_STAGES = 2,
  parameter logic [7:0] FILL_BYTE   = 8'hFF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] AD,
  input  logic [7:0] DI,
  output logic [7:0] DO,
  input  logic       rw,
  input  logic       cs,
  input  logic       spi_sck,
  input  logic       spi_cs_n,
  input  logic       spi_mosi,
  output logic       spi_miso,
  output logic       spi_miso_oe,
  output logic       irq
);

  typedef enum logic {IDLE = 1'b0, ACTIVE = 1'b1} state_t;

  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sck_sync_q, sck_sync_d;
  logic [SYNC_STAGES-1:0] cs_sync_q, cs_sync_d;
  logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
  logic                   sck_prev_q, sck_prev_d;
  logic                   cs_prev_q, cs_prev_d;
  logic [2:0]             bit_cnt_q, bit_cnt_d;
  logic [6:0]             rx_sh_q, rx_sh_d;
  logic [7:0]             tx_sh_q, tx_sh_d;
  logic [7:0]             tx_buf_q, tx_buf_d;
  logic [7:0]             rx_data_q, rx_data_d;
  logic                   txe_q, txe_d, rxf_q, rxf_d, ovr_q, ovr_d, und_q, und_d;
  logic                   ien_rx_q, ien_rx_d, ien_tx_q, ien_tx_d;
  logic                   skip_fall_q, skip_fall_d;

  logic sck_s, cs_s, mosi_s;
  logic sck_rise, sck_fall, cs_fall;
  logic start, in_act, byte_done, load;
  logic wr_data, wr_stat, rd_data;
  logic unused_di;

  // DI bits with no register behind them
  assign unused_di = ^{DI[7], DI[4], DI[1:0]};

  // Synchroniser shift chains and edge detection on the synced pins
  always_comb begin
    sck_sync_d  = {sck_sync_q[SYNC_STAGES-2:0], spi_sck};
    cs_sync_d   = {cs_sync_q[SYNC_STAGES-2:0], spi_cs_n};
    mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], spi_mosi};
    sck_s       = sck_sync_q[SYNC_STAGES-1];
    cs_s        = cs_sync_q[SYNC_STAGES-1];
    mosi_s      = mosi_sync_q[SYNC_STAGES-1];
    sck_prev_d  = sck_s;
    cs_prev_d   = cs_s;
    sck_rise    = sck_s & ~sck_prev_q;
    sck_fall    = ~sck_s & sck_prev_q;
    cs_fall     = ~cs_s & cs_prev_q;
  end

  // FSM next state: a cs_n fall opens a transfer, cs_n high closes it
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (cs_fall) state_d = ACTIVE;
      ACTIVE:  if (cs_s)    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs: MISO is driven only while selected
  always_comb begin
    spi_miso    = 1'b1;
    spi_miso_oe = 1'b0;
    if (state_q == ACTIVE) begin
      spi_miso    = tx_sh_q[7];
      spi_miso_oe = 1'b1;
    end
  end

  // Shifters, status flags and CPU writes; ordering below sets the collision priorities
  always_comb begin
    start     = (state_q == IDLE) & cs_fall;
    in_act    = (state_q == ACTIVE) & ~cs_s;
    byte_done = in_act & sck_rise & (bit_cnt_q == 3'd7);
    load      = start | byte_done;
    wr_data   = cs & ~rw & (AD == 3'd0);
    wr_stat   = cs & ~rw & (AD == 3'd1);
    rd_data   = cs & rw & (AD == 3'd0);

    bit_cnt_d   = bit_cnt_q;
    rx_sh_d     = rx_sh_q;
    tx_sh_d     = tx_sh_q;
    tx_buf_d    = tx_buf_q;
    rx_data_d   = rx_data_q;
    txe_d       = txe_q;
    rxf_d       = rxf_q;
    ovr_d       = ovr_q;
    und_d       = und_q;
    ien_rx_d    = ien_rx_q;
    ien_tx_d    = ien_tx_q;
    skip_fall_d = skip_fall_q;

    // W1C first so a same-cycle set below overrides the clear
    if (wr_stat) begin
      if (DI[2]) ovr_d = 1'b0;
      if (DI[3]) und_d = 1'b0;
      ien_rx_d = DI[5];
      ien_tx_d = DI[6];
    end

    // Deselect or new select: forget any partial byte
    if (start || ((state_q == ACTIVE) && cs_s)) begin
      bit_cnt_d   = 3'd0;
      skip_fall_d = 1'b0;
    end

    if (in_act && sck_rise) begin
      rx_sh_d   = {rx_sh_q[5:0], mosi_s};
      bit_cnt_d = bit_cnt_q + 3'd1;
    end

    // The fall right after a byte boundary must keep the freshly loaded MSB
    if (in_act && sck_fall) begin
      if (skip_fall_q) skip_fall_d = 1'b0;
      else             tx_sh_d     = {tx_sh_q[6:0], 1'b0};
    end

    if (byte_done) begin
      rx_data_d   = {rx_sh_q, mosi_s};
      skip_fall_d = 1'b1;
      if (rxf_q && !rd_data) ovr_d = 1'b1;
      rxf_d = 1'b1;
    end else if (rd_data) begin
      rxf_d = 1'b0;
    end

    // Reload uses pre-write tx_buf/TXE; a same-cycle DATA write lands afterwards
    if (load) begin
      if (txe_q) begin
        tx_sh_d = FILL_BYTE;
        und_d   = 1'b1;
      end else begin
        tx_sh_d = tx_buf_q;
        txe_d   = 1'b1;
      end
    end

    if (wr_data) begin
      tx_buf_d = DI;
      txe_d    = 1'b0;
    end
  end

  // CPU read mux and interrupt
  always_comb begin
    case (AD)
      3'd0:    DO = rx_data_q;
      3'd1:    DO = {1'b0, ien_tx_q, ien_rx_q, (state_q == ACTIVE), und_q, ovr_q, txe_q, rxf_q};
      default: DO = 8'hFF;
    endcase
    irq = (rxf_q & ien_rx_q) | (txe_q & ien_tx_q);
  end

  // State registers; cs_n chain resets low so a held-low pin never looks like a fresh fall
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      sck_sync_q  <= '0;
      cs_sync_q   <= '0;
      mosi_sync_q <= '0;
      sck_prev_q  <= 1'b0;
      cs_prev_q   <= 1'b0;
      bit_cnt_q   <= 3'd0;
      rx_sh_q     <= 7'd0;
      tx_sh_q     <= 8'd0;
      tx_buf_q    <= 8'd0;
      rx_data_q   <= 8'd0;
      txe_q       <= 1'b1;
      rxf_q       <= 1'b0;
      ovr_q       <= 1'b0;
      und_q       <= 1'b0;
      ien_rx_q    <= 1'b0;
      ien_tx_q    <= 1'b0;
      skip_fall_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      sck_sync_q  <= sck_sync_d;
      cs_sync_q   <= cs_sync_d;
      mosi_sync_q <= mosi_sync_d;
      sck_prev_q  <= sck_prev_d;
      cs_prev_q   <= cs_prev_d;
      bit_cnt_q   <= bit_cnt_d;
      rx_sh_q     <= rx_sh_d;
      tx_sh_q     <= tx_sh_d;
      tx_buf_q    <= tx_buf_d;
      rx_data_q   <= rx_data_d;
      txe_q       <= txe_d;
      rxf_q       <= rxf_d;
      ovr_q       <= ovr_d;
      und_q       <= und_d;
      ien_rx_q    <= ien_rx_d;
      ien_tx_q    <= ien_tx_d;
      skip_fall_q <= skip_fall_d;
    end
  end

endmodule
